// File: rtl/score_tracker_pkg.sv
// Shared types and default sizes for the score tracker.
package score_tracker_pkg;

  localparam int DEF_NUM_PLAYERS = 8;
  localparam int DEF_SCORE_W     = 7;
  localparam int DEF_ID_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EVAL = 2'd2
  } state_t;

  typedef logic [DEF_SCORE_W-1:0] score_t;
  typedef logic [DEF_ID_W-1:0]    player_id_t;

endpackage

// File: rtl/score_record_ram.sv
// Per-player best-score store: synchronous read, single write port,
// per-entry valid bits cleared by async active-low reset.
module score_record_ram #(
  parameter int NUM_PLAYERS = 8,
  parameter int SCORE_W     = 7,
  parameter int ID_W        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_rd_en,
  input  logic [ID_W-1:0]    i_rd_addr,
  output logic [SCORE_W-1:0] o_rd_best,
  output logic               o_rd_valid,
  input  logic               i_wr_en,
  input  logic [ID_W-1:0]    i_wr_addr,
  input  logic [SCORE_W-1:0] i_wr_score
);

  logic [SCORE_W-1:0]     r_mem [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_vld;
  logic                   w_rd_in_range;
  logic                   w_wr_in_range;

  assign w_rd_in_range = 32'(i_rd_addr) < NUM_PLAYERS;
  assign w_wr_in_range = 32'(i_wr_addr) < NUM_PLAYERS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_wr_en && w_wr_in_range) begin
      r_vld[i_wr_addr] <= 1'b1;
    end
  end

  // Score contents need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_wr_en && w_wr_in_range) begin
      r_mem[i_wr_addr] <= i_wr_score;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_valid <= 1'b0;
    end else if (i_rd_en) begin
      o_rd_valid <= w_rd_in_range & r_vld[i_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      o_rd_best <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Tracks the lowest score per player and globally; reports win flags with a strobe.
// Define SCORE_TRACKER_STICKY_EN to hold the result until the next start edge.
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int ID_W        = DEF_ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_req,
  input  logic [SCORE_W-1:0] score,
  input  logic [ID_W-1:0]    playerID,
  input  logic               isGuest,
  output logic               personal_winner,
  output logic               global_winner,
  output logic               valid
);

  state_t             r_state;
  logic               r_req_q;
  logic [SCORE_W-1:0] r_score;
  logic [ID_W-1:0]    r_id;
  logic               r_guest;
  logic [SCORE_W-1:0] r_glob_best;
  logic               r_glob_valid;

  logic               w_start;
  logic               w_capture;
  logic [SCORE_W-1:0] w_rec_best;
  logic               w_rec_valid;
  logic               w_pw;
  logic               w_gw;
  logic               w_rd_en;
  logic               w_wr_en;

  assign w_start   = score_req & ~r_req_q;
  assign w_capture = (r_state == IDLE) & w_start;
  assign w_rd_en   = (r_state == READ);
  assign w_pw      = ~r_guest & (~w_rec_valid | (r_score < w_rec_best));
  assign w_gw      = ~r_glob_valid | (r_score < r_glob_best);
  assign w_wr_en   = (r_state == EVAL) & w_pw;

  score_record_ram #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .SCORE_W     (SCORE_W),
    .ID_W        (ID_W)
  ) u_ram (
    .clk        (clk),
    .rst_n      (rst),
    .i_rd_en    (w_rd_en),
    .i_rd_addr  (r_id),
    .o_rd_best  (w_rec_best),
    .o_rd_valid (w_rec_valid),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (r_id),
    .i_wr_score (r_score)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_req_q         <= 1'b0;
      r_glob_valid    <= 1'b0;
      valid           <= 1'b0;
      personal_winner <= 1'b0;
      global_winner   <= 1'b0;
    end else begin
      r_req_q <= score_req;
`ifndef SCORE_TRACKER_STICKY_EN
      valid           <= 1'b0;
      personal_winner <= 1'b0;
      global_winner   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= READ;
`ifdef SCORE_TRACKER_STICKY_EN
            valid           <= 1'b0;
            personal_winner <= 1'b0;
            global_winner   <= 1'b0;
`endif
          end
        end
        READ: r_state <= EVAL;
        EVAL: begin
          valid           <= 1'b1;
          personal_winner <= w_pw;
          global_winner   <= w_gw;
          if (w_gw) r_glob_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Out-of-range slots fold into the guest path so they never touch a record.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_score <= score;
      r_id    <= playerID;
      r_guest <= isGuest | (32'(playerID) >= NUM_PLAYERS);
    end
    if ((r_state == EVAL) && w_gw) begin
      r_glob_best <= r_score;
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with a per-cycle reference model.
module tb_score_tracker;

  localparam int NP = 8;
  localparam int SW = 7;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          score_req = 1'b0;
  logic [SW-1:0] score = '0;
  logic [IW-1:0] playerID = '0;
  logic          isGuest = 1'b0;
  logic          personal_winner;
  logic          global_winner;
  logic          valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;

  score_tracker #(.NUM_PLAYERS(NP), .SCORE_W(SW), .ID_W(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .score_req       (score_req),
    .score           (score),
    .playerID        (playerID),
    .isGuest         (isGuest),
    .personal_winner (personal_winner),
    .global_winner   (global_winner),
    .valid           (valid)
  );

  always #5 clk = ~clk;

  // Reference model: records as plain arrays, one pending request at a time.
  int best [NP];
  bit has  [NP];
  int gbest;
  bit ghas;
  bit m_prev, m_pend;
  int m_due, m_id, m_s;
  bit m_g;
  bit exp_v, exp_p, exp_g;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      for (int i = 0; i < NP; i++) has[i] = 1'b0;
      ghas = 1'b0; m_prev = 1'b0; m_pend = 1'b0;
      exp_v = 1'b0; exp_p = 1'b0; exp_g = 1'b0;
    end else begin
      if (score_req && !m_prev && !m_pend) begin
        m_pend = 1'b1; m_due = cyc + 2;
        m_id = int'(playerID); m_s = int'(score); m_g = isGuest;
      end
      exp_v = 1'b0; exp_p = 1'b0; exp_g = 1'b0;
      if (m_pend && cyc == m_due) begin
        bit guest;
        guest = m_g || (m_id >= NP);
        exp_v = 1'b1;
        exp_p = !guest && (!has[m_id] || m_s < best[m_id]);
        exp_g = !ghas || m_s < gbest;
        if (exp_p) begin best[m_id] = m_s; has[m_id] = 1'b1; end
        if (exp_g) begin gbest = m_s; ghas = 1'b1; end
        m_pend = 1'b0;
      end
      m_prev = score_req;
    end
  end

  always @(posedge clk) begin
    #1;
    if (valid) pulses++;
    checks += 3;
    if (valid !== exp_v) begin
      failures++;
      $display("FAIL model_valid cyc=%0d actual=%b required=%b", cyc, valid, exp_v);
    end
    if (personal_winner !== exp_p) begin
      failures++;
      $display("FAIL model_personal cyc=%0d actual=%b required=%b", cyc, personal_winner, exp_p);
    end
    if (global_winner !== exp_g) begin
      failures++;
      $display("FAIL model_global cyc=%0d actual=%b required=%b", cyc, global_winner, exp_g);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Drive one request edge, then check latency, flags and strobe width against literals.
  task automatic submit(input int id, input int s, input bit g,
                        input int ep, input int eg, input string name);
    int n;
    @(negedge clk);
    playerID = IW'(id); score = SW'(s); isGuest = g; score_req = 1'b1;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        score_req = 1'b0;
        playerID = IW'($urandom); score = SW'($urandom); isGuest = 1'($urandom);
      end
      if (valid) begin n = k; break; end
    end
    chk({name, "_latency"}, n, 3);
    chk({name, "_personal"}, personal_winner, ep);
    chk({name, "_global"}, global_winner, eg);
    @(posedge clk); #1;
    chk({name, "_strobe_1cyc"}, valid, 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("reset_valid", valid, 0);
    chk("reset_personal", personal_winner, 0);
    chk("reset_global", global_winner, 0);
    rst = 1'b1;
    repeat (130) @(negedge clk);

    submit(2, 2, 0, 1, 1, "id2_first");
    submit(2, 1, 0, 1, 1, "id2_better");
    submit(2, 1, 0, 0, 0, "id2_tie");
    submit(1, 2, 0, 1, 0, "id1_first");
    submit(1, 3, 0, 0, 0, "id1_worse");
    submit(4, 0, 1, 0, 1, "guest_zero");
    submit(4, 5, 0, 1, 0, "id4_after_guest");

    // Level held high for 10 cycles must trigger once.
    base = pulses;
    @(negedge clk);
    playerID = 3'd3; score = 7'd6; isGuest = 1'b0; score_req = 1'b1;
    repeat (10) @(negedge clk);
    score_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_level_pulses", pulses - base, 1);

    // A fresh edge landing while the first request is in flight is dropped.
    base = pulses;
    @(negedge clk);
    playerID = 3'd5; score = 7'd7; isGuest = 1'b0; score_req = 1'b1;
    @(negedge clk); score_req = 1'b0;
    @(negedge clk); playerID = 3'd6; score = 7'd0; score_req = 1'b1;
    @(negedge clk); score_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_edge_pulses", pulses - base, 1);

    // Reset asserted while the request sits in READ.
    base = pulses;
    @(negedge clk);
    playerID = 3'd2; score = 7'd0; isGuest = 1'b0; score_req = 1'b1;
    @(negedge clk);
    rst = 1'b0; score_req = 1'b0;
    @(negedge clk);
    chk("midreset_valid", valid, 0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("midreset_pulses", pulses - base, 0);

    submit(2, 9, 0, 1, 1, "after_reset");
    submit(0, 127, 0, 1, 0, "id0_max");
    submit(0, 127, 0, 0, 0, "id0_max_tie");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
